// File: rtl/freq_div_ctrl.sv
// Programmable square-wave divider: first oSIG rise H cycles after an accepted start, then a toggle every H cycles.
// Config backpressure: oCFG_READY drops while a select change waits for the next toggle edge.
module freq_div_ctrl #(
  parameter int BASE_DIV = 6_250_000,
  parameter int CNT_W    = 26
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSTART,
  input  logic       iSTOP,
  input  logic [7:0] iCOUNT,
  input  logic [1:0] iSEL,
  input  logic       iCFG_VALID,
  output logic       oCFG_READY,
  output logic       oSIG,
  output logic       oTICK,
  output logic       oRUN,
  output logic       oDONE
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state;
  logic [1:0]       selAct;
  logic [1:0]       selPend;
  logic             pend;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       perCnt;
  logic [7:0]       perTgt;

  logic       cfgXfer;
  logic       toggleNow;
  logic       fallNow;
  logic       stopLow;
  logic       endRun;
  logic [7:0] perNext;
  logic [1:0] selNext;

  function automatic logic [CNT_W-1:0] halfM1(input logic [1:0] s);
    case (s)
      2'd0:    halfM1 = CNT_W'(BASE_DIV - 1);
      2'd1:    halfM1 = CNT_W'(2 * BASE_DIV - 1);
      2'd2:    halfM1 = CNT_W'(4 * BASE_DIV - 1);
      default: halfM1 = CNT_W'(BASE_DIV / 2 - 1);
    endcase
  endfunction

  assign oCFG_READY = !pend;
  assign oRUN       = (state != IDLE);

  always_comb begin
    cfgXfer   = iCFG_VALID && !pend;
    toggleNow = (state != IDLE) && (cnt == '0);
    fallNow   = toggleNow && oSIG;
    perNext   = perCnt + 8'd1;
    // A stop while low ends immediately, even if a rising toggle was due.
    stopLow   = (state == RUN) && iSTOP && !oSIG;
    endRun    = stopLow ||
                (fallNow && (((perTgt != 8'd0) && (perNext == perTgt)) ||
                             (state == STOPPING) || iSTOP));
    selNext   = pend ? selPend : selAct;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      selAct  <= 2'd0;
      selPend <= 2'd0;
      pend    <= 1'b0;
      cnt     <= '0;
      perCnt  <= 8'd0;
      perTgt  <= 8'd0;
      oSIG    <= 1'b0;
      oTICK   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      oTICK <= 1'b0;
      oDONE <= 1'b0;
      if (state == IDLE) begin
        oSIG <= 1'b0;
        if (cfgXfer) selAct <= iSEL;
        // Start loads the pre-transfer select; a same-edge config shows up at the first toggle.
        if (iSTART && !iSTOP) begin
          state  <= RUN;
          cnt    <= halfM1(selAct);
          perCnt <= 8'd0;
          perTgt <= iCOUNT;
        end
      end else if (endRun) begin
        state  <= IDLE;
        oSIG   <= 1'b0;
        oTICK  <= fallNow;
        oDONE  <= 1'b1;
        cnt    <= '0;
        selAct <= cfgXfer ? iSEL : selNext;
        pend   <= 1'b0;
        if (fallNow) perCnt <= perNext;
      end else begin
        if (toggleNow) begin
          oSIG   <= !oSIG;
          oTICK  <= 1'b1;
          cnt    <= halfM1(selNext);
          selAct <= selNext;
          pend   <= 1'b0;
          if (fallNow) perCnt <= perNext;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
        if ((state == RUN) && iSTOP) state <= STOPPING;
        if (cfgXfer) begin
          selPend <= iSEL;
          pend    <= 1'b1;
        end
      end
    end
  end

endmodule
